// File: rtl/load_ctrl_if.sv
// Loader-side write bus and BRAM port of the program-load controller.
// The slave modport is the controller; the master modport is the loader/BRAM side.
interface load_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              i_ld_wr_en;
  logic [ADDR_W-1:0] i_ld_addr;
  logic [DATA_W-1:0] i_ld_data;
  logic              i_fifo_empty;

  logic              o_bram_en;
  logic              o_bram_we;
  logic [ADDR_W-1:0] o_bram_addr;
  logic [DATA_W-1:0] o_bram_wdata;

  modport master (
    output i_ld_wr_en,
    output i_ld_addr,
    output i_ld_data,
    output i_fifo_empty,
    input  o_bram_en,
    input  o_bram_we,
    input  o_bram_addr,
    input  o_bram_wdata
  );

  modport slave (
    input  i_ld_wr_en,
    input  i_ld_addr,
    input  i_ld_data,
    input  i_fifo_empty,
    output o_bram_en,
    output o_bram_we,
    output o_bram_addr,
    output o_bram_wdata
  );
endinterface

// File: rtl/load_ctrl.sv
// Program-load controller: holds the CPU in reset while the loader fills BRAM, ends the
// download on a line-idle timeout, then hands the BRAM port to the CPU fetch path.
module load_ctrl #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned IDLE_TIMEOUT = 1024,
  parameter int unsigned MAX_WORDS    = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load_start,
  input  logic              i_cpu_rd_en,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  load_ctrl_if.slave        bus,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_word_count,
  output logic              o_err
);

  localparam int unsigned   CntW    = $clog2(IDLE_TIMEOUT);
  localparam logic [CntW-1:0] IdleTop = CntW'(IDLE_TIMEOUT - 1);
  localparam logic [ADDR_W:0] MaxCnt  = (ADDR_W + 1)'(MAX_WORDS);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StRun} state_e;

  state_e            r_state, w_state_d;
  logic [ADDR_W:0]   r_word_count, w_word_count_d;
  logic [CntW-1:0]   r_idle_cnt, w_idle_cnt_d;
  logic              r_err, w_err_d;
  logic              r_pipe_we, w_pipe_we_d;
  logic [ADDR_W-1:0] r_pipe_addr, w_pipe_addr_d;
  logic [DATA_W-1:0] r_pipe_data, w_pipe_data_d;

  logic w_line_idle;
  logic w_armed;
  logic w_room;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_word_count <= '0;
      r_idle_cnt   <= '0;
      r_err        <= 1'b0;
      r_pipe_we    <= 1'b0;
      r_pipe_addr  <= '0;
      r_pipe_data  <= '0;
    end else begin
      r_state      <= w_state_d;
      r_word_count <= w_word_count_d;
      r_idle_cnt   <= w_idle_cnt_d;
      r_err        <= w_err_d;
      r_pipe_we    <= w_pipe_we_d;
      r_pipe_addr  <= w_pipe_addr_d;
      r_pipe_data  <= w_pipe_data_d;
    end
  end

  always_comb begin
    w_line_idle    = !bus.i_ld_wr_en && bus.i_fifo_empty;
    w_armed        = (r_word_count != '0);
    w_room         = (r_word_count < MaxCnt);
    w_state_d      = r_state;
    w_word_count_d = r_word_count;
    w_idle_cnt_d   = r_idle_cnt;
    w_err_d        = r_err;
    w_pipe_we_d    = 1'b0;
    w_pipe_addr_d  = r_pipe_addr;
    w_pipe_data_d  = r_pipe_data;

    case (r_state)
      StIdle: begin
        if (i_load_start) begin
          w_state_d      = StLoad;
          w_word_count_d = '0;
          w_idle_cnt_d   = '0;
        end
      end
      StLoad: begin
        if (bus.i_ld_wr_en) begin
          if (w_room) begin
            w_pipe_we_d    = 1'b1;
            w_pipe_addr_d  = bus.i_ld_addr;
            w_pipe_data_d  = bus.i_ld_data;
            w_word_count_d = r_word_count + 1'b1;
          end else begin
            w_err_d = 1'b1;
          end
        end
        // Counter saturates so an unarmed empty line cannot wrap around.
        if (!w_line_idle) begin
          w_idle_cnt_d = '0;
        end else if (w_armed && (r_idle_cnt == IdleTop)) begin
          w_state_d = StFlush;
        end else if (r_idle_cnt != IdleTop) begin
          w_idle_cnt_d = r_idle_cnt + 1'b1;
        end
      end
      StFlush: begin
        if (bus.i_ld_wr_en) begin
          w_err_d = 1'b1;
        end
        w_state_d = StRun;
      end
      StRun: begin
        if (bus.i_ld_wr_en) begin
          w_err_d = 1'b1;
        end
        if (i_load_start) begin
          w_state_d      = StLoad;
          w_word_count_d = '0;
          w_idle_cnt_d   = '0;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Port select depends only on the registered state, never on loader inputs.
  always_comb begin
    o_cpu_rst    = (r_state != StRun);
    o_busy       = (r_state == StLoad) || (r_state == StFlush);
    o_done       = (r_state == StRun);
    o_word_count = r_word_count;
    o_err        = r_err;
    if (r_state == StRun) begin
      bus.o_bram_en    = i_cpu_rd_en;
      bus.o_bram_we    = 1'b0;
      bus.o_bram_addr  = i_cpu_addr;
      bus.o_bram_wdata = '0;
    end else begin
      bus.o_bram_en    = r_pipe_we;
      bus.o_bram_we    = r_pipe_we;
      bus.o_bram_addr  = r_pipe_addr;
      bus.o_bram_wdata = r_pipe_data;
    end
  end

endmodule

// File: tb/tb_load_ctrl.sv
// Bench for load_ctrl: a timestamp-based reference model predicts mode, counters and BRAM
// writes; a negedge monitor checks the DUT against it while directed and random stimulus runs.
module tb_load_ctrl;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned T  = 16;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          cpu_rd_en = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_rst, busy, done, err;
  logic [AW:0]   word_count;

  load_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  load_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .IDLE_TIMEOUT(T), .MAX_WORDS(MW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_load_start(load_start),
    .i_cpu_rd_en(cpu_rd_en),
    .i_cpu_addr(cpu_addr),
    .bus(bus),
    .o_cpu_rst(cpu_rst),
    .o_busy(busy),
    .o_done(done),
    .o_word_count(word_count),
    .o_err(err)
  );

  always #5 clk = ~clk;

  typedef enum int {MIdle, MLoad, MFlush, MRun} mmode_e;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int unsigned   due;
  } wr_t;

  mmode_e      m_mode = MIdle;
  int unsigned m_count = 0;
  logic        m_err = 1'b0;
  int unsigned m_quiet = 0;
  logic        m_idle;
  int unsigned cyc = 0;
  wr_t         exp_q[$];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a load ends once T consecutive idle cycles follow the last activity.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode  = MIdle;
        m_count = 0;
        m_err   = 1'b0;
        exp_q.delete();
      end else begin
        cyc++;
        m_idle = !bus.i_ld_wr_en && bus.i_fifo_empty;
        case (m_mode)
          MIdle: if (load_start) begin
            m_mode = MLoad; m_count = 0; m_quiet = cyc;
          end
          MLoad: begin
            if (bus.i_ld_wr_en) begin
              if (m_count < MW) begin
                e.a = bus.i_ld_addr; e.d = bus.i_ld_data; e.due = cyc;
                exp_q.push_back(e);
                m_count++;
              end else begin
                m_err = 1'b1;
              end
            end
            if (!m_idle) m_quiet = cyc;
            else if (m_count >= 1 && (cyc - m_quiet) >= T) m_mode = MFlush;
          end
          MFlush: begin
            if (bus.i_ld_wr_en) m_err = 1'b1;
            m_mode = MRun;
          end
          default: begin
            if (bus.i_ld_wr_en) m_err = 1'b1;
            if (load_start) begin
              m_mode = MLoad; m_count = 0; m_quiet = cyc;
            end
          end
        endcase
      end
    end
  end

  // Monitor: compares status every cycle and pops expected writes when they are due.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      chk("cpu_rst", 32'(cpu_rst), 32'(m_mode != MRun));
      chk("busy", 32'(busy), 32'(m_mode == MLoad || m_mode == MFlush));
      chk("done", 32'(done), 32'(m_mode == MRun));
      chk("word_count", 32'(word_count), m_count);
      chk("err", 32'(err), 32'(m_err));
      if (m_mode == MRun) begin
        chk("run_en", 32'(bus.o_bram_en), 32'(cpu_rd_en));
        chk("run_we", 32'(bus.o_bram_we), 0);
        chk("run_addr", 32'(bus.o_bram_addr), 32'(cpu_addr));
        chk("run_wdata", 32'(bus.o_bram_wdata), 0);
      end else begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          chk("wr_missed_due", exp_q[0].due, cyc);
          void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          chk("wr_we", 32'(bus.o_bram_we), 1);
          chk("wr_en", 32'(bus.o_bram_en), 1);
          chk("wr_addr", 32'(bus.o_bram_addr), 32'(e.a));
          chk("wr_data", 32'(bus.o_bram_wdata), 32'(e.d));
        end else begin
          chk("quiet_we", 32'(bus.o_bram_we), 0);
          chk("quiet_en", 32'(bus.o_bram_en), 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_ld_wr_en = 1'b1; bus.i_ld_addr = a; bus.i_ld_data = d; bus.i_fifo_empty = 1'b0;
    tick();
    bus.i_ld_wr_en = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int unsigned at);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    at = cyc;
    if (!done) chk("done_timeout", 32'(done), 1);
  endtask

  initial begin
    int unsigned last, at;
    bus.i_ld_wr_en = 1'b0; bus.i_ld_addr = '0; bus.i_ld_data = '0; bus.i_fifo_empty = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(word_count), 0);
    chk("rst_addr", 32'(bus.o_bram_addr), 0);
    rst = 1'b0;

    // Four words then idle: RUN exactly T+1 cycles after the last write.
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 1; i <= 4; i++) wr(AW'(i), DW'(16'h1111 * i));
    last = cyc;
    bus.i_fifo_empty = 1'b1;
    wait_done(3 * T, at);
    chk("run_latency", at - last, T + 1);
    chk("count4", 32'(word_count), 4);
    chk("run_cpu_rst", 32'(cpu_rst), 0);

    // RUN: fetch pass-through, dropped loader write, start with simultaneous write.
    cpu_rd_en = 1'b1; cpu_addr = 8'h10;
    #1;
    chk("fetch_en", 32'(bus.o_bram_en), 1);
    chk("fetch_addr", 32'(bus.o_bram_addr), 32'h10);
    bus.i_ld_wr_en = 1'b1; bus.i_ld_addr = 8'h33; bus.i_ld_data = 16'hDEAD;
    #1;
    chk("run_wr_we", 32'(bus.o_bram_we), 0);
    tick();
    chk("run_wr_err", 32'(err), 1);
    load_start = 1'b1;
    tick();
    load_start = 1'b0; bus.i_ld_wr_en = 1'b0; cpu_rd_en = 1'b0;
    chk("restart_cpu_rst", 32'(cpu_rst), 1);
    chk("restart_count", 32'(word_count), 0);

    // Empty line without any word never times out.
    repeat (3 * T) tick();
    chk("empty_busy", 32'(busy), 1);
    chk("empty_cpu_rst", 32'(cpu_rst), 1);

    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_err", 32'(err), 0);
    load_start = 1'b1; tick(); load_start = 1'b0;

    // Non-empty FIFO holds off the timeout; then overflow past MAX_WORDS.
    wr(8'h20, 16'hA001);
    bus.i_fifo_empty = 1'b0;
    repeat (2 * T) tick();
    chk("nonempty_busy", 32'(busy), 1);
    wr(8'h21, 16'hA002);
    chk("count2", 32'(word_count), 2);
    for (int i = 0; i < 4; i++) begin
      wr(AW'(8'h22 + i), DW'(16'hB000 + i));
      if (i == 1) chk("err_before_ovf", 32'(err), 0);
      if (i == 2) chk("err_after_ovf", 32'(err), 1);
    end
    chk("count_max", 32'(word_count), MW);
    bus.i_fifo_empty = 1'b1;
    wait_done(3 * T, at);

    // Random bursts and quiet gaps.
    for (int b = 0; b < 40; b++) begin
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
        load_start = ($urandom_range(0, 7) == 0);
        bus.i_ld_wr_en = $urandom_range(0, 1) == 1;
        bus.i_ld_addr = AW'($urandom);
        bus.i_ld_data = DW'($urandom);
        bus.i_fifo_empty = $urandom_range(0, 1) == 1;
        cpu_rd_en = $urandom_range(0, 1) == 1;
        cpu_addr = AW'($urandom);
        tick();
      end
      bus.i_ld_wr_en = 1'b0; bus.i_fifo_empty = 1'b1;
      for (int k = 0; k < int'($urandom_range(0, 2 * T)); k++) begin
        load_start = ($urandom_range(0, 29) == 0);
        cpu_rd_en = $urandom_range(0, 1) == 1;
        cpu_addr = AW'($urandom);
        tick();
      end
      load_start = 1'b0;
    end
    cpu_rd_en = 1'b0;

    // Reset in the middle of an accepted write.
    for (int n = 0; n < 3 * T && !done && !(busy && word_count == 0); n++) tick();
    if (done) begin
      load_start = 1'b1; tick(); load_start = 1'b0;
    end
    chk("pre_rst_busy", 32'(busy), 1);
    bus.i_ld_wr_en = 1'b1; bus.i_ld_addr = 8'h5A; bus.i_ld_data = 16'hC0DE;
    tick();
    chk("pre_rst_we", 32'(bus.o_bram_we), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(bus.o_bram_we), 0);
    chk("mid_rst_cpu_rst", 32'(cpu_rst), 1);
    chk("mid_rst_count", 32'(word_count), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    #1 rst = 1'b0;
    bus.i_ld_wr_en = 1'b0;
    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
